// File: rtl/bus_master_if.sv
// Initiator-side bus interface for one master port: takes single core
// commands, arbitrates for the bus, runs one strobed access with timeout
// and grant-withdrawal retry, and returns a one-cycle response.
module bus_master_if #(
  parameter int unsigned ADDR_W   = 30,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_W     = 8,
  parameter int unsigned HOLD_BUS = 0
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wr_data,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rd_data,
  output logic              bus_req,
  input  logic              bus_grnt,
  output logic              bus_as_n,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_n
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  localparam logic            HOLD    = (HOLD_BUS != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;

  logic              cmd_ready_d;
  logic              resp_valid_d;
  logic              resp_err_d;
  logic [DATA_W-1:0] resp_rd_data_d;
  logic              bus_req_d;
  logic              bus_as_n_d;
  logic              bus_rw_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [DATA_W-1:0] bus_wr_data_d;

  logic done;
  logic err;

  // Next-state, command latch, timeout counter and next registered outputs
  always_comb begin
    state_d        = state_q;
    rw_d           = rw_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    cnt_d          = cnt_q;
    cmd_ready_d    = 1'b0;
    resp_valid_d   = 1'b0;
    resp_err_d     = 1'b0;
    resp_rd_data_d = '0;
    done           = 1'b0;
    err            = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          rw_d        = cmd_rw;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wr_data;
          cmd_ready_d = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_grnt) begin
          cnt_d   = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!bus_grnt) begin
          // Grant lost: back off and retry the same latched command
          cnt_d   = '0;
          state_d = S_REQ;
        end else if (!bus_rdy_n) begin
          done           = 1'b1;
          resp_rd_data_d = rw_q ? bus_rd_data : '0;
        end else if (cnt_q == TO_LAST) begin
          done = 1'b1;
          err  = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end

        if (done) begin
          resp_valid_d = 1'b1;
          resp_err_d   = err;
          if (HOLD && cmd_valid) begin
            rw_d        = cmd_rw;
            addr_d      = cmd_addr;
            wdata_d     = cmd_wr_data;
            cmd_ready_d = 1'b1;
            cnt_d       = '0;
            state_d     = S_ACCESS;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    bus_req_d     = (state_d == S_REQ) || (state_d == S_ACCESS);
    bus_as_n_d    = (state_d != S_ACCESS);
    bus_rw_d      = (state_d == S_ACCESS) ? rw_d : 1'b0;
    bus_addr_d    = (state_d == S_ACCESS) ? addr_d : '0;
    bus_wr_data_d = (state_d == S_ACCESS) ? wdata_d : '0;
  end

  // State, latched command and registered outputs
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q      <= S_IDLE;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      cmd_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rd_data <= '0;
      bus_req      <= 1'b0;
      bus_as_n     <= 1'b1;
      bus_rw       <= 1'b0;
      bus_addr     <= '0;
      bus_wr_data  <= '0;
    end else begin
      state_q      <= state_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      cmd_ready    <= cmd_ready_d;
      resp_valid   <= resp_valid_d;
      resp_err     <= resp_err_d;
      resp_rd_data <= resp_rd_data_d;
      bus_req      <= bus_req_d;
      bus_as_n     <= bus_as_n_d;
      bus_rw       <= bus_rw_d;
      bus_addr     <= bus_addr_d;
      bus_wr_data  <= bus_wr_data_d;
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench: u_dut (HOLD_BUS=0, TIMEOUT=4) and u_hold (HOLD_BUS=1).
module tb_bus_master_if;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rest;
  logic              cv, cv2;
  logic              crw;
  logic [ADDR_W-1:0] caddr;
  logic [DATA_W-1:0] cwd;
  logic              grnt, grnt2;
  logic [DATA_W-1:0] rd_data;
  logic              rdy_n;

  logic              cr, rv, re, breq, bas_n, brw;
  logic [DATA_W-1:0] rdd, bwd;
  logic [ADDR_W-1:0] baddr;
  logic              cr2, rv2, re2, breq2, bas_n2, brw2;
  logic [DATA_W-1:0] rdd2, bwd2;
  logic [ADDR_W-1:0] baddr2;

  int checks = 0;
  int errors = 0;

  bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4), .TO_W(8), .HOLD_BUS(0)) u_dut (
    .clk(clk), .rest(rest),
    .cmd_valid(cv), .cmd_ready(cr), .cmd_rw(crw), .cmd_addr(caddr), .cmd_wr_data(cwd),
    .resp_valid(rv), .resp_err(re), .resp_rd_data(rdd),
    .bus_req(breq), .bus_grnt(grnt), .bus_as_n(bas_n), .bus_rw(brw),
    .bus_addr(baddr), .bus_wr_data(bwd), .bus_rd_data(rd_data), .bus_rdy_n(rdy_n)
  );

  bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(255), .TO_W(8), .HOLD_BUS(1)) u_hold (
    .clk(clk), .rest(rest),
    .cmd_valid(cv2), .cmd_ready(cr2), .cmd_rw(crw), .cmd_addr(caddr), .cmd_wr_data(cwd),
    .resp_valid(rv2), .resp_err(re2), .resp_rd_data(rdd2),
    .bus_req(breq2), .bus_grnt(grnt2), .bus_as_n(bas_n2), .bus_rw(brw2),
    .bus_addr(baddr2), .bus_wr_data(bwd2), .bus_rd_data(rd_data), .bus_rdy_n(rdy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rest = 1'b0; cv = 1'b0; cv2 = 1'b0; crw = 1'b0; caddr = '0; cwd = '0;
    grnt = 1'b0; grnt2 = 1'b0; rd_data = '0; rdy_n = 1'b1;
    step(); step();

    // Reset values
    chk("rst_cmd_ready", 64'(cr), 64'd0);
    chk("rst_resp_valid", 64'(rv), 64'd0);
    chk("rst_resp_err", 64'(re), 64'd0);
    chk("rst_rd_data", 64'(rdd), 64'd0);
    chk("rst_bus_req", 64'(breq), 64'd0);
    chk("rst_as_n", 64'(bas_n), 64'd1);
    chk("rst_bus_addr", 64'(baddr), 64'd0);
    chk("rst_hold_as_n", 64'(bas_n2), 64'd1);

    // Grant while idle is ignored
    rest = 1'b1; grnt = 1'b1;
    step(); step();
    chk("idle_grnt_req", 64'(breq), 64'd0);
    chk("idle_grnt_as_n", 64'(bas_n), 64'd1);

    // Read, immediate grant and ready
    cv = 1'b1; crw = 1'b1; caddr = 30'h10; rd_data = 32'hDEADBEEF;
    step();
    chk("rd_cmd_ready", 64'(cr), 64'd1);
    chk("rd_req_t1", 64'(breq), 64'd1);
    chk("rd_as_n_t1", 64'(bas_n), 64'd1);
    cv = 1'b0; caddr = '0; rdy_n = 1'b0;
    step();
    chk("rd_as_n_t2", 64'(bas_n), 64'd0);
    chk("rd_addr_t2", 64'(baddr), 64'h10);
    chk("rd_rw_t2", 64'(brw), 64'd1);
    chk("rd_cmd_ready_t2", 64'(cr), 64'd0);
    step();
    chk("rd_resp_valid", 64'(rv), 64'd1);
    chk("rd_resp_data", 64'(rdd), 64'hDEADBEEF);
    chk("rd_resp_err", 64'(re), 64'd0);
    chk("rd_req_drop", 64'(breq), 64'd0);
    chk("rd_as_n_t3", 64'(bas_n), 64'd1);
    chk("rd_addr_t3", 64'(baddr), 64'd0);
    rdy_n = 1'b1; grnt = 1'b0;
    step();
    chk("rd_resp_pulse", 64'(rv), 64'd0);

    // Write, grant delayed 5 cycles, ready on 3rd strobe cycle
    cv = 1'b1; crw = 1'b0; caddr = 30'h44; cwd = 32'h12345678;
    step();
    chk("wr_cmd_ready", 64'(cr), 64'd1);
    cv = 1'b0; cwd = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wr_wait_req", 64'(breq), 64'd1);
      chk("wr_wait_as_n", 64'(bas_n), 64'd1);
      chk("wr_wait_cr", 64'(cr), 64'd0);
    end
    grnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wr_strobe", 64'(bas_n), 64'd0);
      chk("wr_data", 64'(bwd), 64'h12345678);
      chk("wr_rw", 64'(brw), 64'd0);
      chk("wr_no_resp", 64'(rv), 64'd0);
    end
    rdy_n = 1'b0;
    step();
    chk("wr_resp_valid", 64'(rv), 64'd1);
    chk("wr_resp_err", 64'(re), 64'd0);
    chk("wr_resp_data", 64'(rdd), 64'd0);
    chk("wr_as_n_end", 64'(bas_n), 64'd1);
    rdy_n = 1'b1; grnt = 1'b0;
    step();
    chk("wr_resp_pulse", 64'(rv), 64'd0);

    // Timeout with TIMEOUT=4
    cv = 1'b1; crw = 1'b1; caddr = 30'h30; grnt = 1'b1;
    step();
    cv = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("to_strobe", 64'(bas_n), 64'd0);
      chk("to_no_resp", 64'(rv), 64'd0);
      step();
    end
    chk("to_resp_valid", 64'(rv), 64'd1);
    chk("to_resp_err", 64'(re), 64'd1);
    chk("to_resp_data", 64'(rdd), 64'd0);
    chk("to_as_n_end", 64'(bas_n), 64'd1);
    chk("to_req_end", 64'(breq), 64'd0);
    grnt = 1'b0;
    step();
    chk("to_resp_pulse", 64'(rv), 64'd0);
    chk("to_idle_req", 64'(breq), 64'd0);

    // Grant withdrawn during the 2nd strobe cycle, regranted 3 cycles later
    cv = 1'b1; crw = 1'b0; caddr = 30'h50; cwd = 32'hCAFE0001; grnt = 1'b1;
    step();
    cv = 1'b0; caddr = '0; cwd = '0;
    step();
    chk("ab_strobe1", 64'(bas_n), 64'd0);
    chk("ab_addr1", 64'(baddr), 64'h50);
    step();
    chk("ab_strobe2", 64'(bas_n), 64'd0);
    grnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ab_off_as_n", 64'(bas_n), 64'd1);
      chk("ab_off_addr", 64'(baddr), 64'd0);
      chk("ab_off_wdata", 64'(bwd), 64'd0);
      chk("ab_off_req", 64'(breq), 64'd1);
      chk("ab_off_resp", 64'(rv), 64'd0);
    end
    grnt = 1'b1;
    step();
    chk("ab_retry_as_n", 64'(bas_n), 64'd0);
    chk("ab_retry_addr", 64'(baddr), 64'h50);
    chk("ab_retry_wdata", 64'(bwd), 64'hCAFE0001);
    rdy_n = 1'b0;
    step();
    chk("ab_resp_valid", 64'(rv), 64'd1);
    chk("ab_resp_err", 64'(re), 64'd0);
    rdy_n = 1'b1; grnt = 1'b0;
    step();
    chk("ab_one_resp", 64'(rv), 64'd0);

    // HOLD_BUS=1: back-to-back reads at 0x20 and 0x24
    cv2 = 1'b1; crw = 1'b1; caddr = 30'h20; grnt2 = 1'b1; rdy_n = 1'b0;
    rd_data = 32'hAAAA0020;
    step();
    chk("hb_cmd_ready1", 64'(cr2), 64'd1);
    chk("hb_req1", 64'(breq2), 64'd1);
    cv2 = 1'b0;
    step();
    chk("hb_strobe1", 64'(bas_n2), 64'd0);
    chk("hb_addr1", 64'(baddr2), 64'h20);
    chk("hb_cr_strobe1", 64'(cr2), 64'd0);
    cv2 = 1'b1; caddr = 30'h24;
    step();
    chk("hb_resp1", 64'(rv2), 64'd1);
    chk("hb_data1", 64'(rdd2), 64'hAAAA0020);
    chk("hb_cmd_ready2", 64'(cr2), 64'd1);
    chk("hb_req_held", 64'(breq2), 64'd1);
    chk("hb_strobe2", 64'(bas_n2), 64'd0);
    chk("hb_addr2", 64'(baddr2), 64'h24);
    cv2 = 1'b0; rd_data = 32'hBBBB0024;
    step();
    chk("hb_resp2", 64'(rv2), 64'd1);
    chk("hb_data2", 64'(rdd2), 64'hBBBB0024);
    chk("hb_err2", 64'(re2), 64'd0);
    chk("hb_req_drop", 64'(breq2), 64'd0);
    chk("hb_as_n_end", 64'(bas_n2), 64'd1);
    rdy_n = 1'b1; grnt2 = 1'b0;
    step();
    chk("hb_resp_end", 64'(rv2), 64'd0);
    chk("hb_dut_idle", 64'(breq), 64'd0);

    // Reset asserted mid-access
    cv = 1'b1; crw = 1'b1; caddr = 30'h60; grnt = 1'b1; rdy_n = 1'b1;
    step();
    cv = 1'b0;
    step();
    chk("rs_strobe", 64'(bas_n), 64'd0);
    #2 rest = 1'b0;
    #1;
    chk("rs_as_n_async", 64'(bas_n), 64'd1);
    chk("rs_req_async", 64'(breq), 64'd0);
    chk("rs_addr_async", 64'(baddr), 64'd0);
    step();
    chk("rs_no_resp", 64'(rv), 64'd0);
    rest = 1'b1; grnt = 1'b0;
    step();
    chk("rs_no_resp2", 64'(rv), 64'd0);
    chk("rs_idle_req", 64'(breq), 64'd0);

    // Normal command after reset release
    cv = 1'b1; crw = 1'b1; caddr = 30'h70; grnt = 1'b1; rd_data = 32'h76543210;
    step();
    chk("pr_cmd_ready", 64'(cr), 64'd1);
    cv = 1'b0; rdy_n = 1'b0;
    step();
    chk("pr_strobe", 64'(bas_n), 64'd0);
    chk("pr_addr", 64'(baddr), 64'h70);
    step();
    chk("pr_resp_valid", 64'(rv), 64'd1);
    chk("pr_resp_data", 64'(rdd), 64'h76543210);
    rdy_n = 1'b1; grnt = 1'b0;
    step();
    chk("pr_resp_pulse", 64'(rv), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
- Initiator-side bus interface for one bus master port (m0..m3).
- Accepts single read/write commands from a core-side requester and raises bus_req toward the bus arbiter.
- Waits for bus_grnt, then drives address strobe, address, read/write and write data, and waits for the slave's ready.
- Returns read data or a timeout error to the requester, then releases the bus.
- One instance per master; bus outputs are zero when the port is not the active owner, so the shared bus can OR them together.

Parameters:
ADDR_W, 30, word-address width.
DATA_W, 32, data width.
TIMEOUT, 255, max ACCESS cycles waiting for bus_rdy_n before error; legal range 1..2^TO_W-1.
TO_W, 8, timeout counter width.
HOLD_BUS, 0, 1 = keep ownership for a command presented in the completion cycle.

Ports:
clk  in  1  system clock, rising edge
rest  in  1  asynchronous active-low reset
cmd_valid  in  1  core command present
cmd_ready  out  1  command accepted this cycle (pulse)
cmd_rw  in  1  1=read, 0=write
cmd_addr  in  ADDR_W  command address
cmd_wr_data  in  DATA_W  write data
resp_valid  out  1  response pulse, one cycle
resp_err  out  1  timeout flag, qualified by resp_valid
resp_rd_data  out  DATA_W  read data, qualified by resp_valid
bus_req  out  1  request to arbiter (mN_req)
bus_grnt  in  1  grant from arbiter (mN_grnt)
bus_as_n  out  1  address strobe, active low
bus_rw  out  1  1=read, 0=write
bus_addr  out  ADDR_W  bus address
bus_wr_data  out  DATA_W  bus write data
bus_rd_data  in  DATA_W  slave read data
bus_rdy_n  in  1  slave ready, active low

Behaviour:
- Reset (rest=0, asynchronous):
  - State goes to IDLE.
  - Outputs: cmd_ready=0, resp_valid=0, resp_err=0, resp_rd_data=0, bus_req=0, bus_as_n=1, bus_rw=0, bus_addr=0, bus_wr_data=0.
  - Latched command and timeout counter are cleared.
- All outputs are registered.
- Bus-side outputs are Moore-decoded from state:
  - bus_as_n=0 only in ACCESS.
  - bus_rw, bus_addr, bus_wr_data carry the latched command in ACCESS and are 0 in all other states.
  - bus_req=1 in REQ and ACCESS.
- IDLE:
  - If cmd_valid=1: latch rw/addr/wr_data, pulse cmd_ready for one cycle, go to REQ.
  - bus_req is high from the cycle after acceptance.
- REQ:
  - Hold bus_req=1.
  - On bus_grnt=1 sampled: clear the timeout counter and go to ACCESS. The first strobe cycle is the cycle after grant is seen.
- ACCESS: sample bus_rdy_n and bus_grnt every cycle. Priority, highest first:
  - bus_grnt=0 (grant withdrawn): abort. Go to REQ with bus_as_n=1 next cycle, keep the latched command, no response, counter cleared; the access is retried.
  - bus_rdy_n=0: complete. Next cycle resp_valid=1, resp_err=0; resp_rd_data=bus_rd_data for reads, 0 for writes.
  - Counter reaches TIMEOUT-1 with bus_rdy_n=1: complete with resp_err=1, resp_rd_data=0.
  - Otherwise: increment the counter.
- Completion:
  - HOLD_BUS=0: go to IDLE. bus_req drops next cycle. A cmd_valid present in the completion cycle is not accepted until IDLE.
  - HOLD_BUS=1 and cmd_valid=1 in the completion cycle: accept it in that cycle (cmd_ready pulse), latch it, stay in ACCESS with bus_req held high; the new strobe starts next cycle, counter cleared.
  - HOLD_BUS=1 and cmd_valid=0: go to IDLE.
- Minimum latency, grant and ready immediate: cmd accepted at T0, bus_req at T1, grant seen at T1 → strobe T2, rdy_n=0 at T2 → resp_valid at T3.
- At most one outstanding command. cmd_ready is never asserted in REQ. In ACCESS it is asserted only in the completion cycle with HOLD_BUS=1.
- resp_valid is exactly one cycle, with no backpressure.
- Reset asserted mid-ACCESS: bus_as_n and bus_req deassert immediately (asynchronous). The command is dropped and no response is issued.
- Grant while not requesting (IDLE): ignored; bus outputs stay 0.

Test Plan:
- Read, immediate grant and ready: cmd_rw=1, addr=0x0000_0010, bus_rd_data=0xDEADBEEF → bus_as_n low 1 cycle with bus_addr=0x10; resp_valid at T3 with resp_rd_data=0xDEADBEEF, resp_err=0; bus_req low the cycle after completion.
- Write, grant delayed 5 cycles and ready after 3 strobe cycles: wr_data=0x12345678 → bus_as_n low exactly 3 cycles with bus_wr_data=0x12345678, bus_rw=0; resp_valid, resp_err=0, resp_rd_data=0.
- Timeout with TIMEOUT=4 and bus_rdy_n held 1 → bus_as_n low exactly 4 cycles; resp_valid=1, resp_err=1, resp_rd_data=0; return to IDLE.
- Grant withdrawn on 2nd strobe cycle, regranted 3 cycles later → bus_as_n high and outputs 0 while ungranted; access retried with the same addr/data; exactly one resp_valid.
- HOLD_BUS=1, two back-to-back reads at 0x20 and 0x24 with immediate ready → bus_req never drops between them; second strobe on the cycle after the first completion; two resp_valid pulses in consecutive cycles with the correct data.
- Reset pulsed during ACCESS → bus_as_n=1 and bus_req=0 in the same cycle as reset assertion; no resp_valid; a cmd after release proceeds normally.
